// File: rtl/vram_arbiter_pkg.sv
// Shared types and constants for the VRAM arbiter slice.
package vram_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] DISP_BASE_DEFAULT = 16'h7800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        CPU  = 2'd2
    } state_e;

    // Tile map address: base plus the 10-bit tile index, wrapping at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [9:0]        offset);
        return base + {{(ADDR_W-10){1'b0}}, offset};
    endfunction

endpackage

// File: rtl/vram_slot_decode.sv
// Display slot decoder: flags cycles reserved for a tile map fetch.
module vram_slot_decode
    import vram_arbiter_pkg::*;
#(
    parameter logic [1:0] DISP_SLOT_MASK = 2'b11
) (
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    output logic       disp_slot
);

    // Row position plays no part in slot timing; only the column phase matters.
    logic [8:0] unused_vpos;
    assign unused_vpos = vpos;

    // A slot is any visible cycle whose masked column phase is zero.
    always_comb begin
        disp_slot = display_on && ((hpos[1:0] & DISP_SLOT_MASK) == 2'b00);
    end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: single-port RAM shared between display fetch and CPU.
// Optional build macro VRAM_ARB_BLANK_ONLY_EN restricts CPU grants to blanking.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DISP_BASE      = DISP_BASE_DEFAULT,
    parameter logic [1:0]        DISP_SLOT_MASK = 2'b11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        hpos,
    input  logic [8:0]        vpos,
    input  logic              display_on,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   vram_addr_q, vram_addr_d;
    logic                vram_we_q, vram_we_d;
    logic [DATA_W-1:0]   vram_wdata_q, vram_wdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                cpu_rd_q, cpu_rd_d;
    logic                disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0]   disp_data_q, disp_data_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                disp_slot;
    logic                cpu_free;
    logic                cpu_grant;
    logic [9:0]          tile_offset;

    vram_slot_decode #(
        .DISP_SLOT_MASK(DISP_SLOT_MASK)
    ) u_slot_decode (
        .hpos      (hpos),
        .vpos      (vpos),
        .display_on(display_on),
        .disp_slot (disp_slot)
    );

    // CPU is eligible unless its access cycle or its ack cycle is in progress.
    always_comb begin
        tile_offset = {vpos[7:3], hpos[7:3]};
        cpu_free    = cpu_req && (state_q != CPU) && !cpu_ack_q;
`ifdef VRAM_ARB_BLANK_ONLY_EN
        cpu_grant   = cpu_free && !display_on;
`else
        cpu_grant   = cpu_free;
`endif
    end

    // Next state with the RAM bus registered alongside it; display wins ties.
    always_comb begin
        state_d      = IDLE;
        vram_addr_d  = vram_addr_q;
        vram_we_d    = 1'b0;
        vram_wdata_d = vram_wdata_q;
        cpu_rd_d     = cpu_rd_q;
        cpu_ack_d    = (state_q == CPU);
        disp_valid_d = (state_q == DISP);
        if (disp_slot) begin
            state_d     = DISP;
            vram_addr_d = tile_addr(DISP_BASE, tile_offset);
        end else if (cpu_grant) begin
            state_d      = CPU;
            vram_addr_d  = cpu_addr;
            vram_we_d    = cpu_we;
            vram_wdata_d = cpu_wdata;
            cpu_rd_d     = !cpu_we;
        end
    end

    // RAM data is forwarded live in the completion cycle and held afterwards.
    always_comb begin
        disp_data_d = disp_valid_q ? vram_rdata : disp_data_q;
        cpu_rdata_d = (cpu_ack_q && cpu_rd_q) ? vram_rdata : cpu_rdata_q;
    end

    // State and output registers; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            vram_addr_q  <= '0;
            vram_we_q    <= 1'b0;
            vram_wdata_q <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rd_q     <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            vram_addr_q  <= vram_addr_d;
            vram_we_q    <= vram_we_d;
            vram_wdata_q <= vram_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rd_q     <= cpu_rd_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    assign vram_addr  = vram_addr_q;
    assign vram_we    = vram_we_q;
    assign vram_wdata = vram_wdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_d;
    assign cpu_rdata  = cpu_rdata_d;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter; honours VRAM_ARB_BLANK_ONLY_EN when defined.
module tb_vram_arbiter;

    localparam logic [15:0] BASE = 16'h7800;
    localparam logic [1:0]  MASK = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  hpos = '0;
    logic [8:0]  vpos = '0;
    logic        display_on = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [15:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [7:0]  disp_data;
    logic        disp_valid;

    vram_arbiter #(
        .DISP_BASE     (BASE),
        .DISP_SLOT_MASK(MASK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hpos      (hpos),
        .vpos      (vpos),
        .display_on(display_on),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .vram_addr (vram_addr),
        .vram_we   (vram_we),
        .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata),
        .disp_data (disp_data),
        .disp_valid(disp_valid)
    );

    always #5 clk = ~clk;

    // Power-up contents of the RAM (0x0010 holds 0x3C).
    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h2C;
    endfunction

    // Synchronous RAM, read-first, one cycle latency.
    logic [7:0] ram    [0:65535];
    bit         ram_wr [0:65535];
    always @(posedge clk) begin
        vram_rdata <= ram_wr[vram_addr] ? ram[vram_addr] : init_byte(vram_addr);
        if (vram_we) begin
            ram[vram_addr]    <= vram_wdata;
            ram_wr[vram_addr] <= 1'b1;
        end
    end

    typedef struct {
        int         due;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    exp_t        disp_q[$];
    exp_t        ack_q[$];
    logic [7:0]  shadow [logic [15:0]];
    int          cyc = 0;
    int          zero_cyc = -1;
    bit          mon_en = 1'b0;
    logic [15:0] exp_addr = '0;
    logic        exp_we = 1'b0;
    logic [7:0]  exp_wdata = '0;
    logic [7:0]  held_rdata = '0;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        return shadow.exists(a) ? shadow[a] : init_byte(a);
    endfunction

    // Reference model: per cycle, apply the arbitration rules to the sampled inputs.
    initial begin : model
        int last_grant;
        int a;
        bit slot;
        bit blank_ok;
        last_grant = -100;
        forever begin
            @(posedge clk);
            if (reset) begin
                disp_q.delete();
                ack_q.delete();
                exp_addr   = '0;
                exp_we     = 1'b0;
                zero_cyc   = cyc + 1;
                mon_en     = 1'b1;
                last_grant = -100;
            end else begin
                exp_we = 1'b0;
                slot   = display_on && ((hpos[1:0] & MASK) == 2'b00);
`ifdef VRAM_ARB_BLANK_ONLY_EN
                blank_ok = !display_on;
`else
                blank_ok = 1'b1;
`endif
                if (slot) begin
                    a        = (int'(BASE) + int'(vpos[7:3]) * 32 + int'(hpos[7:3])) % 65536;
                    exp_addr = 16'(a);
                    disp_q.push_back('{due: cyc + 2, rd: 1'b1, data: model_read(16'(a))});
                end else if (cpu_req && blank_ok && (cyc - last_grant >= 3)) begin
                    last_grant = cyc;
                    exp_addr   = cpu_addr;
                    exp_we     = cpu_we;
                    exp_wdata  = cpu_wdata;
                    if (cpu_we) begin
                        shadow[cpu_addr] = cpu_wdata;
                        ack_q.push_back('{due: cyc + 2, rd: 1'b0, data: 8'h00});
                    end else begin
                        ack_q.push_back('{due: cyc + 2, rd: 1'b1, data: model_read(cpu_addr)});
                    end
                end
            end
            cyc++;
        end
    end

    // Monitor: compare DUT outputs on the falling edge against scoreboard contents.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cyc == zero_cyc) begin
                    check("reset_outputs",
                          {cpu_ack, disp_valid, vram_we, vram_addr, vram_wdata, cpu_rdata, disp_data},
                          '0);
                    held_rdata = '0;
                end
                check("vram_addr", vram_addr, exp_addr);
                check("vram_we", vram_we, exp_we);
                if (exp_we) check("vram_wdata", vram_wdata, exp_wdata);

                if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
                    e = disp_q.pop_front();
                    check("disp_valid", disp_valid, 1);
                    check("disp_data", disp_data, e.data);
                end else begin
                    check("disp_valid_idle", disp_valid, 0);
                end

                if (ack_q.size() > 0 && ack_q[0].due == cyc) begin
                    e = ack_q.pop_front();
                    check("cpu_ack", cpu_ack, 1);
                    if (e.rd) held_rdata = e.data;
                end else begin
                    check("cpu_ack_idle", cpu_ack, 0);
                end
                check("cpu_rdata", cpu_rdata, held_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (hpos == 9'd339) begin
            hpos = '0;
            vpos = (vpos == 9'd261) ? 9'd0 : vpos + 9'd1;
        end else begin
            hpos = hpos + 9'd1;
        end
    endtask

    task automatic wait_ack(input string name, input int maxc, input bit drop, output int n);
        n = 0;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (cpu_ack) begin
                n = i;
                if (drop) cpu_req = 1'b0;
                return;
            end
        end
        check({name, "_timeout"}, cpu_ack, 1);
    endtask

    task automatic new_txn();
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = ($urandom_range(0, 1) == 1) ? BASE + 16'($urandom_range(0, 1023))
                                                : 16'($urandom_range(0, 63));
        cpu_wdata = 8'($urandom);
    endtask

    initial begin : stimulus
        int n;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Display fetch at vpos 9, hpos 16.
        vpos = 9'd9; hpos = 9'd16; display_on = 1'b1;
        tick();
        display_on = 1'b0;
        check("fetch_addr_7822", vram_addr, 16'h7822);
        repeat (3) tick();

        // Write raised in a display slot at hpos 4.
        vpos = 9'd9; hpos = 9'd4; display_on = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (hpos == 9'd8) display_on = 1'b0;
            if (cpu_ack) begin
                n = i;
                cpu_req = 1'b0;
                break;
            end
        end
`ifdef VRAM_ARB_BLANK_ONLY_EN
        check("conflict_ack_latency", n, 6);
`else
        check("conflict_ack_latency", n, 3);
`endif
        tick();

        // Blanking read of 0x0010.
        display_on = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        wait_ack("blank_read", 10, 1'b1, n);
        check("blank_read_latency", n, 2);
        check("blank_read_data", cpu_rdata, 8'h3C);
        tick();

        // Two reads with cpu_req held throughout.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        wait_ack("b2b_first", 10, 1'b0, n);
        cpu_addr = 16'h7822;
        wait_ack("b2b_second", 10, 1'b1, n);
        check("b2b_gap", n, 3);
        tick();

        // Reset during the CPU cycle, request held across it.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'h5A;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_no_ack", cpu_ack, 0);
        wait_ack("post_reset", 10, 1'b1, n);
        tick();

        // Randomized traffic over a few scan lines crossing into vertical blank.
        hpos = '0; vpos = 9'd236;
        for (int i = 0; i < 3000; i++) begin
            tick();
            display_on = (hpos < 9'd256) && (vpos < 9'd240);
            reset = ($urandom_range(0, 399) == 0);
            if (cpu_req && cpu_ack) begin
                if ($urandom_range(0, 2) == 0) new_txn();
                else cpu_req = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                new_txn();
            end
        end

        // Drain outstanding work.
        reset = 1'b0;
        display_on = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_ack) cpu_req = 1'b0;
        end
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
- REQ-001 The block SHALL have parameter DISP_BASE, default 16'h7800, giving the base address of the display tile map.
- REQ-002 The block SHALL have parameter DISP_SLOT_MASK, default 2'b11; a display slot occurs when (hpos[1:0] & DISP_SLOT_MASK) == 0.
- REQ-003 clk  input  1  the single clock for all logic.
- REQ-004 reset  input  1  synchronous, active-high reset.
- REQ-005 hpos  input  9  horizontal position from the video timing generator.
- REQ-006 vpos  input  9  vertical position from the video timing generator.
- REQ-007 display_on  input  1  high inside the visible area.
- REQ-008 cpu_req  input  1  CPU access request, held high until cpu_ack.
- REQ-009 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
- REQ-010 cpu_addr  input  16  CPU address; stable while cpu_req is high.
- REQ-011 cpu_wdata  input  8  CPU write data; stable while cpu_req is high.
- REQ-012 cpu_ack  output  1  one-cycle completion pulse.
- REQ-013 cpu_rdata  output  8  read data, valid in the cpu_ack cycle of a read.
- REQ-014 vram_addr  output  16  RAM address.
- REQ-015 vram_we  output  1  RAM write enable.
- REQ-016 vram_wdata  output  8  RAM write data.
- REQ-017 vram_rdata  input  8  synchronous RAM read data, one cycle after the address.
- REQ-018 disp_data  output  8  fetched tile byte.
- REQ-019 disp_valid  output  1  one-cycle pulse; disp_data is valid in that cycle.

Function
- REQ-020 The FSM SHALL have exactly three states: IDLE, DISP, CPU. Each RAM access occupies exactly one cycle in DISP or CPU.
- REQ-021 A display slot SHALL exist when display_on = 1 and the slot condition holds. In that case the next state is DISP, regardless of cpu_req.
- REQ-022 In DISP, vram_addr SHALL equal DISP_BASE + {vpos[7:3], hpos[7:3]} (10-bit offset, zero-extended, modulo-2^16 sum), with vram_we = 0.
- REQ-023 disp_valid SHALL pulse, with disp_data = vram_rdata, on the cycle after each DISP cycle.
- REQ-024 When no display slot exists, cpu_req = 1, and no CPU access is outstanding, the next state SHALL be CPU.
- REQ-025 In CPU, vram_addr SHALL be cpu_addr, vram_we SHALL be cpu_we, and vram_wdata SHALL be cpu_wdata.
- REQ-026 cpu_ack SHALL pulse on the cycle after the CPU cycle. For a read, cpu_rdata SHALL equal vram_rdata in that cycle.
- REQ-027 No new CPU grant SHALL occur in the cpu_ack cycle. A request held high after ack is therefore treated as a new request, granted at the earliest one cycle later.
- REQ-028 Otherwise the state SHALL be IDLE, with vram_we = 0 and vram_addr holding its previous value.
- REQ-029 vram_we SHALL never be 1 outside the CPU state.
- REQ-030 cpu_rdata SHALL hold its value between reads.
- REQ-031 When a display slot and cpu_req occur in the same cycle, display SHALL win. The CPU is served in the next non-display slot, with no request loss.
- REQ-032 hpos/vpos wrap-around SHALL require no special handling; slot decisions depend only on the current inputs.

Reset
- REQ-033 While reset is high, the state SHALL be IDLE and cpu_ack, disp_valid, and vram_we SHALL be 0.
- REQ-034 While reset is high, vram_addr, vram_wdata, cpu_rdata, and disp_data SHALL be 0.
- REQ-035 A CPU or display access in flight at reset SHALL be dropped: no cpu_ack and no disp_valid is generated for it.

Configuration
- REQ-036 With VRAM_ARB_BLANK_ONLY_EN defined, a CPU grant SHALL occur only when display_on = 0. Free cycles inside the visible area stay IDLE.
- REQ-037 Without VRAM_ARB_BLANK_ONLY_EN, CPU grants SHALL use every non-display-slot cycle (REQ-024).

Structure
- REQ-038 A shared package SHALL hold the state encoding (IDLE = 0, DISP = 1, CPU = 2), the address width (16), the data width (8), and the DISP_BASE default.
- REQ-039 The slot decoder, which computes the display-slot condition from hpos, vpos and display_on, SHALL be one sub-module named vram_slot_decode. All other logic stays in vram_arbiter.

Verification
- REQ-040 Display fetch: display_on = 1, vpos = 9, hpos = 16 → vram_addr = 16'h7822 and vram_we = 0. The next cycle has disp_valid = 1 and disp_data = the RAM model byte.
- REQ-041 Conflict: cpu_req write of 8'hA5 to 16'h1234 raised at hpos = 4 (a display slot) → DISP at hpos 4, CPU at hpos 5 with vram_we = 1, cpu_ack at hpos 6.
- REQ-042 Blanking read: display_on = 0, CPU read of 16'h0010, RAM holding 8'h3C → cpu_ack on the second cycle after cpu_req rises, with cpu_rdata = 8'h3C.
- REQ-043 Back-to-back: cpu_req held for two reads → grants are separated by at least one cycle. Exactly two ack pulses occur, and no access is duplicated.
- REQ-044 Reset mid-access: assert reset in the CPU cycle → no cpu_ack, and all outputs are 0 next cycle. A request after reset release completes normally.
- REQ-045 With VRAM_ARB_BLANK_ONLY_EN: cpu_req during display_on = 1 at hpos = 5 → no grant until display_on falls, then ack two cycles later.
